// File: rtl/uart_loopback_fifo.sv
// Byte FIFO plus transmit scheduler between UART_RX and UART_TX; also keeps the last accepted byte.
// Optional macro UART_FIFO_DROP_COUNT_EN adds an 8-bit saturating dropped-byte counter (o_Drop_Count).
module uart_loopback_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_TX_Active,
    input  logic                  i_TX_Done,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [7:0]            o_Last_Byte,
    output logic [ADDR_WIDTH:0]   o_Count,
    output logic                  o_Full,
    output logic                  o_Empty,
`ifdef UART_FIFO_DROP_COUNT_EN
    output logic                  o_Overflow,
    output logic [7:0]            o_Drop_Count
`else
    output logic                  o_Overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [7:0]            r_tx_byte;
    logic [7:0]            r_last_byte;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_launch;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == S_LAUNCH);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign w_push  = i_RX_DV && (!w_full || w_pop);
    assign w_drop  = i_RX_DV && w_full && !w_pop;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        o_TX_DV      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !i_TX_Active) begin
                    w_state_next = S_LAUNCH;
                    w_launch     = 1'b1;
                end
            end
            S_LAUNCH: begin
                o_TX_DV      = 1'b1;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_TX_Done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_RX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_byte <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + ADDR_WIDTH'(1);
                r_last_byte <= i_RX_Byte;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head byte is fetched on the IDLE->LAUNCH edge so it is valid with o_TX_DV and
    // holds until the next launch, independent of later pointer movement.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_tx_byte <= 8'h00;
        end else if (w_launch) begin
            r_tx_byte <= r_mem[r_rd_ptr];
        end
    end

`ifdef UART_FIFO_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_drop_count <= 8'h00;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign o_Drop_Count = r_drop_count;
    assign o_Overflow   = (r_drop_count != 8'h00);
`else
    logic r_overflow;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_Overflow = r_overflow;
`endif

    assign o_TX_Byte   = r_tx_byte;
    assign o_Last_Byte = r_last_byte;
    assign o_Count     = r_count;
    assign o_Full      = w_full;
    assign o_Empty     = w_empty;

endmodule
